rkob_fifo_ctrl: RTL and testbench

Flow-controlled FIFO controller wrapped around one rkob_ptp_ram instance. It owns the write and read pointers, an occupancy counter and full/empty/threshold flags. Writes are accepted only when there is space, and reads only when there is data. Producers and consumers use it instead of free-running address counters, so data cannot be lost or re-read.

---
 rtl/rkob_fifo_ctrl_pkg.sv | 16 +
 rtl/rkob_ptp_ram.sv | 34 +++
 rtl/rkob_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_rkob_fifo_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rkob_fifo_ctrl_pkg.sv
// Shared definitions for the rkob FIFO controller: counter width and
// the wrapping pointer increment used by both FIFO pointers.
package rkob_fifo_ctrl_pkg;

    // Default RAM address width and the matching occupancy counter width.
    // The counter needs one bit more than the address so it can hold DEPTH.
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int CNT_WIDTH      = DEF_ADDR_WIDTH + 1;

    // Next pointer value: wraps from depth-1 back to 0, otherwise increments.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rkob_ptp_ram.sv
// Pseudo two-port RAM: one write port and one read port on a shared
// clock. Reads are registered, so data appears one cycle after re.
// Contents are never reset.
module rkob_ptp_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // Store the write word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register the addressed word so it is available one cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rkob_fifo_ctrl.sv
// Flow-controlled FIFO controller around a single rkob_ptp_ram. Owns the
// pointers, the occupancy counter, the status flags and the sticky
// overflow/underflow indicators. Writes are refused when full and reads
// are refused when empty, so no word can be lost or read twice.
module rkob_fifo_ctrl
    import rkob_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  kill,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_flags
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accept decisions use the registered flags; nothing is accepted
    // while kill is asserted.
    always_comb begin
        wr_acc = wr_en & ~full  & ~kill;
        rd_acc = rd_en & ~empty & ~kill;
    end

    // Occupancy changes only when exactly one side is accepted.
    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers and counter; each pointer wraps at DEPTH-1.
    always_ff @(posedge clk) begin
        if (kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ADDR_WIDTH'(next_ptr(32'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= ADDR_WIDTH'(next_ptr(32'(rd_ptr), DEPTH));
            end
            count <= count_nxt;
        end
    end

    // Status flags registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (kill) begin
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
        end else begin
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == CW'(DEPTH));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
        end
    end

    // Read-valid pulse follows an accepted read by one cycle, matching RAM latency.
    always_ff @(posedge clk) begin
        if (kill) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
        end
    end

    // Sticky error flags; a new rejection wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (kill) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    assign level = count;

    rkob_ptp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (2**ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .re      (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_rkob_fifo_ctrl.sv
// Directed self-checking bench for rkob_fifo_ctrl with a 5-entry FIFO.
module tb_rkob_fifo_ctrl;
    import rkob_fifo_ctrl_pkg::*;

    localparam int DW    = 12;
    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int DEPTH = 5;
    localparam int AFL   = 4;
    localparam int AEL   = 2;

    logic                 clk = 1'b0;
    logic                 kill = 1'b0;
    logic                 wr_en = 1'b0;
    logic [DW-1:0]        wr_data = '0;
    logic                 rd_en = 1'b0;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_WIDTH-1:0] level;
    logic                 overflow;
    logic                 underflow;
    logic                 clr_flags = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    rkob_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AFL),
        .AE_LEVEL   (AEL)
    ) dut (
        .clk          (clk),
        .kill         (kill),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_flags    (clr_flags)
    );

    always #5 clk = ~clk;

    // Occupancy must never exceed DEPTH.
    always @(negedge clk) begin
        if (level > CNT_WIDTH'(DEPTH)) begin
            $display("[TB] FAIL level_bound got=%0d want<=%0d", level, DEPTH);
            n_bad++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then release them.
    task automatic apply_stimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                  input logic clr, input logic k);
        wr_en     = w;
        wr_data   = d;
        rd_en     = r;
        clr_flags = clr;
        kill      = k;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        kill      = 1'b0;
    endtask

    // Expected status flags follow from the occupancy by definition.
    task automatic check_level(input string tag, input int lvl);
        check_output({tag, ".level"}, 32'(level), 32'(lvl));
        check_output({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
        check_output({tag, ".full"},  32'(full),  32'(lvl == DEPTH));
        check_output({tag, ".af"},    32'(almost_full),  32'(lvl >= AFL));
        check_output({tag, ".ae"},    32'(almost_empty), 32'(lvl <= AEL));
    endtask

    task automatic check_read(input string tag, input int val);
        check_output({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
        check_output({tag, ".rd_data"},  32'(rd_data),  32'(val));
    endtask

    initial begin
        int exp_q[$];

        // 1: reset
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_level("reset", 0);
        check_output("reset.rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset.ovf", 32'(overflow), 32'd0);
        check_output("reset.unf", 32'(underflow), 32'd0);

        // 2: fill 0..40, then overflow
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, DW'(i * 10), 1'b0, 1'b0, 1'b0);
            check_level($sformatf("fill%0d", i), i + 1);
        end
        apply_stimulus(1'b1, DW'(50), 1'b0, 1'b0, 1'b0);
        check_level("wr_full", 5);
        check_output("wr_full.ovf", 32'(overflow), 32'd1);

        // 3: drain back-to-back, then underflow
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_read($sformatf("drain%0d", i), i * 10);
            check_level($sformatf("drain%0d", i), 4 - i);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_output("rd_empty.rd_valid", 32'(rd_valid), 32'd0);
        check_output("rd_empty.unf", 32'(underflow), 32'd1);
        check_output("rd_empty.ovf_sticky", 32'(overflow), 32'd1);
        check_level("rd_empty", 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_output("clr.ovf", 32'(overflow), 32'd0);
        check_output("clr.unf", 32'(underflow), 32'd0);

        // 4: pointer wrap
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_read($sformatf("pre_wrap%0d", i), i);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, DW'(60 + 10 * i), 1'b0, 1'b0, 1'b0);
        check_level("wrap_fill", 4);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_read($sformatf("wrap%0d", i), 60 + 10 * i);
        end
        check_level("wrap_done", 0);

        // 5: simultaneous read and write
        apply_stimulus(1'b1, DW'(100), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'(101), 1'b0, 1'b0, 1'b0);
        exp_q = '{100, 101};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, DW'(102 + i), 1'b1, 1'b0, 1'b0);
            exp_q.push_back(102 + i);
            check_read($sformatf("both%0d", i), exp_q.pop_front());
            check_level($sformatf("both%0d", i), 2);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, DW'(106 + i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(106 + i);
        end
        check_level("both_prefull", 5);
        apply_stimulus(1'b1, DW'(109), 1'b1, 1'b0, 1'b0);
        check_read("both_full", exp_q.pop_front());
        check_output("both_full.ovf", 32'(overflow), 32'd1);
        check_level("both_full", 4);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_read($sformatf("both_drain%0d", i), exp_q.pop_front());
        end
        check_level("both_drained", 0);
        apply_stimulus(1'b1, DW'(110), 1'b1, 1'b0, 1'b0);
        check_output("both_empty.rd_valid", 32'(rd_valid), 32'd0);
        check_output("both_empty.unf", 32'(underflow), 32'd1);
        check_output("both_empty.ovf", 32'(overflow), 32'd0);
        check_level("both_empty", 1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_read("both_empty_rb", 110);
        check_output("both_empty_rb.unf", 32'(underflow), 32'd0);

        // 6: kill during an accepted read, then set-wins on overflow
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DW'(200 + i), 1'b0, 1'b0, 1'b0);
        check_level("pre_kill", 3);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_output("kill.rd_valid", 32'(rd_valid), 32'd0);
        check_level("kill", 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("kill_next.rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(300 + i), 1'b0, 1'b0, 1'b0);
        check_level("refill", 5);
        apply_stimulus(1'b1, DW'(399), 1'b0, 1'b1, 1'b0);
        check_output("clr_vs_rej.ovf", 32'(overflow), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_output("clr_only.ovf", 32'(overflow), 32'd0);
        apply_stimulus(1'b1, DW'(398), 1'b0, 1'b0, 1'b1);
        check_output("kill_wr.ovf", 32'(overflow), 32'd0);
        check_level("kill_wr", 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_output("kill_rd.unf", 32'(underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
